// File: rtl/swo_pkg.sv
// Shared definitions for the SWO Manchester transmitter and its receive-side peers.
// Holds the state encoding, parameter defaults, the half-bit width and the H floor helper.
package swo_pkg;

  localparam int HALFBIT_W       = 16;
  localparam int GUARD_BITS_DEF  = 2;
  localparam int MIN_HALFBIT_DEF = 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START_A = 3'd1,
    S_START_B = 3'd2,
    S_BIT_A   = 3'd3,
    S_BIT_B   = 3'd4,
    S_GUARD   = 3'd5
  } swo_state_e;

  function automatic logic [HALFBIT_W-1:0] clamp_halfbit(
    input logic [HALFBIT_W-1:0] len,
    input logic [HALFBIT_W-1:0] floor_len
  );
    return (len < floor_len) ? floor_len : len;
  endfunction

endpackage

// File: rtl/swo_halfbit_timer.sv
// Half-bit timer: counts 0..h-1 and pulses 'last' on the final cycle of each half-bit.
// Held at zero while clr is high so the first half-bit after a start is full length.
module swo_halfbit_timer
  import swo_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [HALFBIT_W-1:0] h,
  output logic                 last
);

  logic [HALFBIT_W-1:0] cnt;

  assign last = !clr && (cnt == (h - HALFBIT_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr || last)
      cnt <= '0;
    else
      cnt <= cnt + HALFBIT_W'(1);
  end

endmodule

// File: rtl/swo_manch_tx.sv
// SWO Manchester transmitter: start bit, back-to-back LSB-first bytes, then a low guard.
// Half-bit length is latched on the IDLE transfer and held until the packet returns to IDLE.
module swo_manch_tx
  import swo_pkg::*;
#(
  parameter int GUARD_BITS  = GUARD_BITS_DEF,
  parameter int MIN_HALFBIT = MIN_HALFBIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [HALFBIT_W-1:0] halfBitLen,
  input  logic [7:0]           dataIn,
  input  logic                 dataValid,
  output logic                 dataReady,
  output logic                 SWOout,
  output logic                 busy
);

  localparam int GUARD_MAX = GUARD_BITS * 2 * 65535;
  localparam int GUARD_W   = (GUARD_MAX > 1) ? $clog2(GUARD_MAX + 1) : 1;
  localparam int MIN_H_I   = (MIN_HALFBIT < 1) ? 1 : MIN_HALFBIT;
  localparam logic [HALFBIT_W-1:0] MIN_H     = HALFBIT_W'(MIN_H_I);
  localparam logic [GUARD_W-1:0]   GUARD_MUL = GUARD_W'(GUARD_BITS * 2);

  swo_state_e           state, state_nxt;
  logic [HALFBIT_W-1:0] h_q, h_nxt;
  logic [7:0]           data_q, data_nxt;
  logic [2:0]           idx_q, idx_nxt, idx_inc;
  logic [GUARD_W-1:0]   gcnt_q, gcnt_nxt, guard_len;
  logic                 swo_nxt, hb_last, xfer, timer_clr, guard_done;

  assign timer_clr  = (state == S_IDLE) || (state == S_GUARD);
  assign guard_len  = GUARD_MUL * GUARD_W'(h_q);
  assign guard_done = (gcnt_q == (guard_len - GUARD_W'(1)));
  assign idx_inc    = idx_q + 3'd1;

  // Ready only where a byte can be consumed: IDLE or the very last cycle of bit 7.
  assign dataReady = !rst && ((state == S_IDLE) ||
                              ((state == S_BIT_B) && (idx_q == 3'd7) && hb_last));
  assign xfer      = dataValid && dataReady;
  assign busy      = (state != S_IDLE);

  swo_halfbit_timer u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .h    (h_q),
    .last (hb_last)
  );

  // IDLE wait | START_A/B start bit halves | BIT_A/B data halves | GUARD trailing low
  always_comb begin
    state_nxt = state;
    h_nxt     = h_q;
    data_nxt  = data_q;
    idx_nxt   = idx_q;
    gcnt_nxt  = gcnt_q;
    swo_nxt   = SWOout;
    case (state)
      S_IDLE: if (xfer) begin
        state_nxt = S_START_A;
        h_nxt     = clamp_halfbit(halfBitLen, MIN_H);
        data_nxt  = dataIn;
        idx_nxt   = 3'd0;
        swo_nxt   = 1'b1;
      end
      S_START_A: if (hb_last) begin
        state_nxt = S_START_B;
        swo_nxt   = 1'b0;
      end
      S_START_B: if (hb_last) begin
        state_nxt = S_BIT_A;
        idx_nxt   = 3'd0;
        swo_nxt   = data_q[0];
      end
      S_BIT_A: if (hb_last) begin
        state_nxt = S_BIT_B;
        swo_nxt   = ~data_q[idx_q];
      end
      S_BIT_B: if (hb_last) begin
        if (idx_q != 3'd7) begin
          state_nxt = S_BIT_A;
          idx_nxt   = idx_inc;
          swo_nxt   = data_q[idx_inc];
        end else if (xfer) begin
          state_nxt = S_BIT_A;
          idx_nxt   = 3'd0;
          data_nxt  = dataIn;
          swo_nxt   = dataIn[0];
        end else begin
          state_nxt = (GUARD_BITS == 0) ? S_IDLE : S_GUARD;
          gcnt_nxt  = '0;
          swo_nxt   = 1'b0;
        end
      end
      S_GUARD: begin
        swo_nxt = 1'b0;
        if (guard_done) begin
          state_nxt = S_IDLE;
          gcnt_nxt  = '0;
        end else begin
          gcnt_nxt = gcnt_q + GUARD_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        swo_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      h_q    <= '0;
      data_q <= '0;
      idx_q  <= '0;
      gcnt_q <= '0;
      SWOout <= 1'b0;
    end else begin
      state  <= state_nxt;
      h_q    <= h_nxt;
      data_q <= data_nxt;
      idx_q  <= idx_nxt;
      gcnt_q <= gcnt_nxt;
      SWOout <= swo_nxt;
    end
  end

endmodule

// File: tb/tb_swo_manch_tx.sv
// Bench for swo_manch_tx: expected line waveform built from the packet rules per packet,
// compared cycle by cycle, with a mid-bit sampler decoding the bytes back.
module tb_swo_manch_tx;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] halfBitLen;
  logic [7:0]  dataIn;
  logic        dataValid;
  logic        dataReady;
  logic        SWOout;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  bit exp_swo[$];
  bit exp_rdy[$];

  swo_manch_tx dut (
    .clk        (clk),
    .rst        (rst),
    .halfBitLen (halfBitLen),
    .dataIn     (dataIn),
    .dataValid  (dataValid),
    .dataReady  (dataReady),
    .SWOout     (SWOout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Line model: start bit, then each byte LSB first, then 2 guard bits low.
  task automatic build_wave(input bq_t bytes, input int h);
    exp_swo.delete();
    exp_rdy.delete();
    for (int c = 0; c < h; c++) begin exp_swo.push_back(1'b1); exp_rdy.push_back(1'b0); end
    for (int c = 0; c < h; c++) begin exp_swo.push_back(1'b0); exp_rdy.push_back(1'b0); end
    foreach (bytes[i]) begin
      for (int b = 0; b < 8; b++) begin
        for (int c = 0; c < h; c++) begin
          exp_swo.push_back(bytes[i][b]); exp_rdy.push_back(1'b0);
        end
        for (int c = 0; c < h; c++) begin
          exp_swo.push_back(~bytes[i][b]); exp_rdy.push_back((b == 7) && (c == h - 1));
        end
      end
    end
    for (int c = 0; c < 4 * h; c++) begin exp_swo.push_back(1'b0); exp_rdy.push_back(1'b0); end
  endtask

  // Entered at a negedge with the DUT idle. abort_at >= 0 pulses rst at that cycle.
  task automatic run_packet(input bq_t bytes, input int hlen_raw, input int abort_at,
                            input bit preload, input logic [7:0] next_byte);
    int         h;
    int         nxt;
    int         last_rdy;
    int         off;
    int         nbits;
    logic [7:0] cur;
    bq_t        got;
    h = (hlen_raw < 1) ? 1 : hlen_raw;
    build_wave(bytes, h);
    last_rdy = -1;
    foreach (exp_rdy[k]) if (exp_rdy[k]) last_rdy = k;
    nbits = 0;
    cur   = 8'h00;
    got.delete();

    halfBitLen = 16'(hlen_raw);
    dataIn     = bytes[0];
    dataValid  = 1'b1;
    #1;
    chk_val("idle_ready", 32'(dataReady), 32'd1);
    chk_val("idle_busy", 32'(busy), 32'd0);
    chk_val("idle_swo", 32'(SWOout), 32'd0);
    @(posedge clk);
    nxt = 1;
    for (int k = 0; k < exp_swo.size(); k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        chk_val("rst_swo", 32'(SWOout), 32'd0);
        chk_val("rst_busy", 32'(busy), 32'd0);
        chk_val("rst_ready", 32'(dataReady), 32'd0);
        dataValid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_val("post_rst_ready", 32'(dataReady), 32'd1);
        chk_val("post_rst_busy", 32'(busy), 32'd0);
        return;
      end
      chk_val("swo", 32'(SWOout), 32'(exp_swo[k]));
      chk_val("busy", 32'(busy), 32'd1);
      chk_val("ready", 32'(dataReady), 32'(exp_rdy[k]));
      off = k - 2 * h;
      if (off >= 0 && off < bytes.size() * 16 * h && (off % (2 * h)) == h / 2) begin
        cur = {SWOout, cur[7:1]};
        nbits++;
        if (nbits % 8 == 0) got.push_back(cur);
      end
      halfBitLen = 16'($urandom);
      if (nxt < bytes.size()) begin
        dataIn    = bytes[nxt];
        dataValid = exp_rdy[k] ? 1'b1 : 1'($urandom_range(0, 1));
        if (exp_rdy[k]) nxt++;
      end else begin
        dataValid = preload && (k >= last_rdy + 3);
        dataIn    = preload ? next_byte : 8'($urandom);
      end
    end
    @(negedge clk);
    chk_val("end_busy", 32'(busy), 32'd0);
    chk_val("end_swo", 32'(SWOout), 32'd0);
    chk_val("end_ready", 32'(dataReady), 32'd1);
    chk_val("decode_count", 32'(got.size()), 32'(bytes.size()));
    foreach (got[i]) if (i < bytes.size()) chk_val("decode_byte", 32'(got[i]), 32'(bytes[i]));
  endtask

  initial begin
    bq_t q;
    rst        = 1'b1;
    dataValid  = 1'b0;
    dataIn     = 8'h00;
    halfBitLen = 16'd0;
    repeat (3) @(negedge clk);
    chk_val("reset_ready", 32'(dataReady), 32'd0);
    chk_val("reset_swo", 32'(SWOout), 32'd0);
    chk_val("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    q.delete(); q.push_back(8'hA5);
    run_packet(q, 4, -1, 1'b0, 8'h00);

    q.delete(); q.push_back(8'h00); q.push_back(8'hFF);
    run_packet(q, 4, -1, 1'b0, 8'h00);

    q.delete(); q.push_back(8'h3C);
    run_packet(q, 0, -1, 1'b0, 8'h00);

    q.delete(); q.push_back(8'h55);
    run_packet(q, 8, 16 + 3 * 16 + 5, 1'b0, 8'h00);
    q.delete(); q.push_back(8'h55);
    run_packet(q, 8, -1, 1'b0, 8'h00);

    q.delete(); q.push_back(8'h12);
    run_packet(q, 2, -1, 1'b1, 8'h81);
    q.delete(); q.push_back(8'h81);
    run_packet(q, 2, -1, 1'b0, 8'h00);

    for (int p = 0; p < 6; p++) begin
      q.delete();
      for (int i = 0; i < $urandom_range(1, 4); i++) q.push_back(8'($urandom));
      run_packet(q, $urandom_range(0, 6), -1, 1'b0, 8'h00);
    end

    q.delete();
    for (int i = 0; i < 64; i++) q.push_back(8'($urandom));
    run_packet(q, 20, -1, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
